// File: rtl/q_pkg.sv
// ---------------------------------------------------------------------------
// q_pkg
//   Definitions shared between the quantizer Q and the logic that consumes
//   its output codes.
//
//   Q_SYM_W      width of one quantized code Qx.
//   Q_SAT_CODE   code the quantizer produces when its input clips.
//   nsyms_width  width needed to hold a symbol count of 0..n inclusive.
// ---------------------------------------------------------------------------
package q_pkg;

  localparam int Q_SYM_W = 2;

  localparam logic [Q_SYM_W-1:0] Q_SAT_CODE = 2'b11;

  function automatic int nsyms_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/q_out_slot.sv
// ---------------------------------------------------------------------------
// q_out_slot
//   Single-entry valid/ready holding register.  A word loaded here stays
//   stable until the consumer takes it.  A load and a drain may happen in
//   the same cycle, so back-to-back words flow at full rate.
//
//   Ports
//     clk, rst      clock; asynchronous active-high reset
//     load          capture load_word/load_nsyms this cycle; the caller
//                   only asserts it while slot_free is 1
//     load_word     word to capture
//     load_nsyms    symbol count to capture
//     out_ready     consumer accepts the held word
//     out_valid     slot holds a word
//     out_word      held word
//     out_nsyms     held symbol count
//     slot_free     slot can take a new word this cycle
// ---------------------------------------------------------------------------
module q_out_slot #(
  parameter int WORD_W = 8,
  parameter int NSYM_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [NSYM_W-1:0] load_nsyms,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  output logic [NSYM_W-1:0] out_nsyms,
  output logic              slot_free
);

  // A drain frees the slot in the same cycle it is refilled.
  assign slot_free = !out_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so that every
  // always_ff reads the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_nsyms <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= load_word;
      out_nsyms <= load_nsyms;
    end else if (out_valid && out_ready) begin
      // Data fields keep their last value; only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/q_symbol_packer.sv
// ---------------------------------------------------------------------------
// q_symbol_packer
//   Packs successive quantized codes Qx into SYMS_PER_WORD-symbol words and
//   presents them on a valid/ready output.  The first symbol accepted into
//   a word lands in the LSBs.  A level-sensitive flush emits a partially
//   filled word, with its unused slots zero.
//
//   Optional build macro QPACK_SAT_CNT_EN adds sat_count, a saturating
//   16-bit count of accepted clip codes (Q_SAT_CODE).
//
//   Ports
//     clk, rst    clock; asynchronous active-high reset
//     in_valid    in_q holds a symbol
//     in_ready    packer accepts in_q this cycle (0 while rst is high)
//     in_q        quantized symbol
//     flush       request to emit the partial word
//     out_valid   out_word/out_nsyms valid
//     out_ready   downstream accepts the word
//     out_word    packed word; symbol k at [SYM_W*k +: SYM_W]
//     out_nsyms   number of valid symbols in out_word
//     sat_count   (QPACK_SAT_CNT_EN only) accepted clip-code count
// ---------------------------------------------------------------------------
module q_symbol_packer
  import q_pkg::*;
#(
  parameter int SYMS_PER_WORD = 4,
  parameter int SYM_W         = Q_SYM_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SYM_W-1:0]                       in_q,
  input  logic                                   flush,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SYM_W*SYMS_PER_WORD-1:0]         out_word,
  output logic [nsyms_width(SYMS_PER_WORD)-1:0]  out_nsyms
`ifdef QPACK_SAT_CNT_EN
  ,
  output logic [15:0]                            sat_count
`endif
);

  localparam int WORD_W = SYM_W * SYMS_PER_WORD;
  localparam int NSYM_W = nsyms_width(SYMS_PER_WORD);
  localparam int CNT_W  = $clog2(SYMS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SYMS_PER_WORD - 1);

  logic [WORD_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              slot_free;
  logic              last_slot;
  logic              accept;
  logic              complete;
  logic              emit;
  logic [WORD_W-1:0] emit_word;
  logic [NSYM_W-1:0] emit_nsyms;

  // Only the symbol that would complete a word needs a free output slot.
  // Earlier symbols just go into acc.
  assign last_slot = (cnt == LAST_SLOT);
  assign in_ready  = !rst && (!last_slot || slot_free);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && last_slot;

  // A full word and a flush in the same cycle produce a single emission.
  // A flush with nothing held and nothing arriving does nothing.
  assign emit = complete || (flush && slot_free && (cnt != '0 || accept));

  // NOTE: every signal driven here is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    emit_word = acc;
    if (accept) begin
      emit_word[SYM_W*cnt +: SYM_W] = in_q;
    end
    emit_nsyms = NSYM_W'(cnt) + NSYM_W'(accept);
  end

  // acc is cleared on every emission, so a partial word is zero-padded.
  // NOTE: acc is a plain register and is reset together with cnt.  This
  // lets a mid-word reset discard the partial word and keeps the zero
  // padding exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (emit) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= emit_word;
      cnt <= cnt + 1'b1;
    end
  end

  q_out_slot #(
    .WORD_W (WORD_W),
    .NSYM_W (NSYM_W)
  ) u_out_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (emit),
    .load_word  (emit_word),
    .load_nsyms (emit_nsyms),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_nsyms  (out_nsyms),
    .slot_free  (slot_free)
  );

`ifdef QPACK_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (accept && (in_q == SYM_W'(Q_SAT_CODE)) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_q_symbol_packer.sv
// ---------------------------------------------------------------------------
// tb_q_symbol_packer
//   Self-checking bench for q_symbol_packer with the default parameters
//   (4 symbols of 2 bits).  The sat_count checks are present only when
//   QPACK_SAT_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_q_symbol_packer;

  localparam int N  = 4;
  localparam int SW = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [SW-1:0] in_q;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_word;
  logic [2:0]   out_nsyms;
`ifdef QPACK_SAT_CNT_EN
  logic [15:0]  sat_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  q_symbol_packer #(
    .SYMS_PER_WORD (N),
    .SYM_W         (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_nsyms (out_nsyms)
`ifdef QPACK_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [1:0] q;
    logic       f;
    logic       r;
    logic       exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_w;
    logic [2:0] exp_n;
  } vec_t;

  vec_t tbl[13];

  // Reference model state: symbols held in the open word, plus one
  // output slot.
  logic [1:0] held[$];
  logic       m_ov;
  logic [7:0] m_w;
  logic [2:0] m_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] q, input logic f, input logic r);
    in_valid  = v;
    in_q      = q;
    flush     = f;
    out_ready = r;
  endtask

  // From one negedge to the next, passing one active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_word", out_word, 8'h00);
    check("rst_out_nsyms", out_nsyms, 3'd0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] pack_held();
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < held.size(); k++) begin
      w[2*k +: 2] = held[k];
    end
    return w;
  endfunction

  initial begin
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // ---------------- table-driven vectors ----------------
    //          v  q  f  r  rdy ov word  n
    tbl[0]  = '{1, 1, 0, 1, 1, 0, 8'h00, 0};
    tbl[1]  = '{1, 2, 0, 1, 1, 0, 8'h00, 0};
    tbl[2]  = '{1, 3, 0, 1, 1, 0, 8'h00, 0};
    tbl[3]  = '{1, 0, 0, 1, 1, 1, 8'h39, 4};
    tbl[4]  = '{1, 3, 0, 1, 1, 0, 8'h00, 0};
    tbl[5]  = '{1, 1, 0, 1, 1, 0, 8'h00, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 1, 8'h07, 2};
    tbl[7]  = '{1, 0, 0, 1, 1, 0, 8'h00, 0};
    tbl[8]  = '{1, 0, 0, 1, 1, 0, 8'h00, 0};
    tbl[9]  = '{1, 0, 0, 1, 1, 0, 8'h00, 0};
    tbl[10] = '{1, 2, 1, 1, 1, 1, 8'h80, 4};
    tbl[11] = '{0, 0, 1, 1, 1, 0, 8'h00, 0};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 8'h00, 0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].q, tbl[i].f, tbl[i].r);
      #1;
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      tick();
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) begin
        check($sformatf("tbl%0d_out_word", i), out_word, tbl[i].exp_w);
        check($sformatf("tbl%0d_out_nsyms", i), out_nsyms, tbl[i].exp_n);
      end
    end

    // ---------------- backpressure: 8 symbols of 3 ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      #1;
      check("bp_w1_in_ready", in_ready, 1'b1);
      tick();
    end
    check("bp_w1_valid", out_valid, 1'b1);
    check("bp_w1_word", out_word, 8'hFF);
    check("bp_w1_nsyms", out_nsyms, 3'd4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      #1;
      check("bp_w2_in_ready", in_ready, 1'b1);
      tick();
      check("bp_hold_word", out_word, 8'hFF);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      #1;
      check("bp_stall_in_ready", in_ready, 1'b0);
      tick();
      check("bp_stall_valid", out_valid, 1'b1);
      check("bp_stall_word", out_word, 8'hFF);
    end
    // Drain word 1 while the 8th symbol completes word 2.
    drive(1'b1, 2'd3, 1'b0, 1'b1);
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    tick();
    check("bp_w2_valid", out_valid, 1'b1);
    check("bp_w2_word", out_word, 8'hFF);
    check("bp_w2_nsyms", out_nsyms, 3'd4);
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    check("bp_empty_valid", out_valid, 1'b0);

    // ---------------- flush held off by a full slot ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    check("fh_hold_word", out_word, 8'hE4);
    drive(1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    check("fh_valid", out_valid, 1'b1);
    check("fh_word", out_word, 8'h02);
    check("fh_nsyms", out_nsyms, 3'd1);
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    check("fh_empty_valid", out_valid, 1'b0);

    // ---------------- reset mid-word with a word held ----------------
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      tick();
    end
    check("mr_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_out_word", out_word, 8'h00);
    check("mr_out_nsyms", out_nsyms, 3'd0);
    check("mr_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      tick();
      check("mr_partial_valid", out_valid, 1'b0);
    end
    drive(1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    check("mr_valid", out_valid, 1'b1);
    check("mr_word", out_word, 8'h55);
    check("mr_nsyms", out_nsyms, 3'd4);
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    tick();

`ifdef QPACK_SAT_CNT_EN
    // ---------------- saturating clip-code counter ----------------
    do_reset();
    @(negedge clk);
    check("sat_reset", sat_count, 16'd0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, (i < 10) ? 2'd3 : 2'd1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    check("sat_count10", sat_count, 16'd10);
    force dut.sat_cnt_q = 16'hFFFD;
    #1;
    release dut.sat_cnt_q;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    check("sat_count_max", sat_count, 16'hFFFF);
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    @(negedge clk);
    held.delete();
    m_ov = 1'b0;
    m_w  = '0;
    m_n  = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic v, f, r, sf, rdy, acc_now, emit_now;
      logic [1:0] q;
      check("rnd_out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("rnd_out_word", out_word, m_w);
        check("rnd_out_nsyms", out_nsyms, m_n);
      end
      v = ($urandom_range(0, 3) != 0);
      q = 2'($urandom);
      f = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, q, f, r);
      #1;
      sf  = !m_ov || r;
      rdy = (held.size() != N - 1) || sf;
      check("rnd_in_ready", in_ready, rdy);

      acc_now = v && rdy;
      if (acc_now) held.push_back(q);
      emit_now = (held.size() == N) || (f && sf && held.size() > 0);
      if (emit_now) begin
        m_ov = 1'b1;
        m_w  = pack_held();
        m_n  = 3'(held.size());
        held.delete();
      end else if (m_ov && r) begin
        m_ov = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
